mat_job_arbiter: RTL and testbench
==================================

# mat_job_arbiter

Job-level round-robin scheduler that shares one `matrix_core` between `NUM_REQ` requesters. Each job is 20 words into the core (16 W, row-major, then 4 X) followed by 4 accumulated results out. The block sits between the requester streams and the core's snk/src ports. It grants the core to one requester for a whole job, muxes that requester's input stream to the core, and routes the core's results back to the same requester.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 1..8.
- `GID_W`, default `(NUM_REQ>1) ? $clog2(NUM_REQ) : 1`: grant-id width.
- `DATA_WIDTH`, `ACC_WIDTH`, `W_DEPTH`, `X_DEPTH`: taken from `constants_pkg`; not overridden.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `req_vld`  in  NUM_REQ  per-requester input word valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_rdy`  out  NUM_REQ  per-requester input ready
- `rsp_vld`  out  NUM_REQ  per-requester result valid
- `rsp_data`  out  ACC_WIDTH  shared result bus, meaningful only under `rsp_vld`
- `rsp_rdy`  in  NUM_REQ  per-requester result ready
- `core_snk_vld`  out  1  to core `snk_vld`
- `core_snk_data`  out  DATA_WIDTH  to core `snk_data`
- `core_snk_rdy`  in  1  from core `snk_rdy`
- `core_src_vld`  in  1  from core `src_vld`
- `core_src_data`  in  ACC_WIDTH  from core `src_data`
- `core_src_rdy`  out  1  to core `src_rdy`
- `busy`  out  1  job in progress (state != IDLE)
- `grant_id`  out  GID_W  current or last granted requester
- `jobs_done`  out  16  completed-job count, wraps at 0xFFFF -> 0

## Operation
- FSM states: IDLE, FEED, DRAIN. Registers: `state`, `grant_id`, `rr_ptr`, `wcnt` (0..W_DEPTH+X_DEPTH-1), `rcnt` (0..X_DEPTH-1), `jobs_done`.
- **IDLE**
  - All `req_rdy`, `rsp_vld`, `core_snk_vld` and `core_src_rdy` are 0.
  - If any `req_vld` is set, pick the first set bit searching from `rr_ptr` upward with wrap.
  - Register it as `grant_id`, clear `wcnt`, go to FEED.
- **FEED** (combinational pass-through)
  - `core_snk_vld = req_vld[grant_id]`, `core_snk_data` = granted slice, `req_rdy[grant_id] = core_snk_rdy`; all other `req_rdy` = 0.
  - `wcnt` increments on each core handshake.
  - On the handshake with `wcnt == W_DEPTH+X_DEPTH-1`: clear `rcnt`, go to DRAIN.
- **DRAIN** (combinational pass-through)
  - `rsp_vld[grant_id] = core_src_vld`, `rsp_data = core_src_data`, `core_src_rdy = rsp_rdy[grant_id]`; other `rsp_vld` = 0.
  - `rcnt` increments per handshake.
  - On the handshake with `rcnt == X_DEPTH-1`: set `rr_ptr = (grant_id+1) mod NUM_REQ`, increment `jobs_done`, go to IDLE.
- A grant holds for the whole job. If the granted requester drops `req_vld` or `rsp_rdy` mid-job, the job stalls; the grant is never pre-empted.
- `core_src_vld` outside DRAIN is ignored (`core_src_rdy` = 0).
- Non-granted requesters are never ready, regardless of their `req_vld`.

## Timing
- Reset values: state=IDLE, `grant_id`=0, `rr_ptr`=0, `wcnt`=`rcnt`=0, `jobs_done`=0, `busy`=0. All handshake outputs are 0 during reset.
- Arbitration latency is 1 cycle: `req_vld` seen in IDLE at cycle t gives FEED and a possible first handshake at t+1.
- FEED and DRAIN add zero latency: the core's ready/valid is visible to the requester in the same cycle.
- Minimum job length is 1 + 20 + core compute + 4 result cycles, plus 1 return cycle in IDLE.
- Back-to-back jobs: there is always at least one IDLE cycle between the last result handshake and the next first word.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N-1,0. With a single active requester it is re-granted every job.
- Reset mid-job: return to IDLE immediately and drop all outputs; the core shares `rst_n` and is reset together.
- `NUM_REQ=1`: `grant_id` is always 0 and the arbitration logic degenerates.

## Structure
- `constants_pkg` supplies `DATA_WIDTH`, `ACC_WIDTH`, `W_DEPTH`, `X_DEPTH`, `MAT_DIM`.
- Add to `constants_pkg`: `JOB_WORDS = W_DEPTH+X_DEPTH` and enum `arb_state_t {ARB_IDLE, ARB_FEED, ARB_DRAIN}`.
- Sub-module `rr_pick`: combinational, parameter `NUM_REQ`. Inputs `req`, `ptr`; outputs `any`, `idx`. It is reused by other shared-resource arbiters.

## Test plan
- Single requester 0: W = 1..16, X = 1,1,1,1 -> rsp to requester 0 = 10, 26, 42, 58; `jobs_done` = 1; `grant_id` = 0.
- Both requesters valid from reset -> requester 0 is served fully before requester 1 sees any `req_rdy`; the second job is granted to 1; `rr_ptr` ends at 0.
- Requester 1 inserts 3 invalid cycles mid-FEED and deasserts `rsp_rdy` for 5 cycles in DRAIN -> correct results, no words lost or duplicated, requester 0 receives no `req_rdy` the whole time.
- W = identity, X = 0xFF,0x01,0x80,0x00 -> results 255, 1, 128, 0; `rsp_vld` asserted only on the granted index.
- `rst_n` asserted after word 10 of a job, then a full new job -> outputs 0 during reset, the new job produces correct results, `jobs_done` counts from 0.
- Three requesters each issue 3 jobs -> grant order 0,1,2,0,1,2,0,1,2 and `jobs_done` = 9.

Source files
------------

// File: rtl/constants_pkg.sv
// Shared matrix-core geometry plus the job arbiter's state encoding.
package constants_pkg;
    localparam int MAT_DIM    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 32;
    localparam int W_DEPTH    = MAT_DIM * MAT_DIM;
    localparam int X_DEPTH    = MAT_DIM;
    localparam int JOB_WORDS  = W_DEPTH + X_DEPTH;

    // Counter widths for the word and result counters of one job
    localparam int WCNT_W = $clog2(JOB_WORDS);
    localparam int RCNT_W = (X_DEPTH > 1) ? $clog2(X_DEPTH) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FEED,
        ARB_DRAIN
    } arb_state_t;
endpackage

// File: rtl/mat_job_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic               any,
    output logic [GID_W-1:0]   idx
);
    int w_best;
    int w_dist;

    // Choose the requester with the smallest wrapped distance from ptr
    always_comb begin
        any    = |req;
        idx    = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NUM_REQ - int'(ptr));
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = GID_W'(j);
            end
        end
    end
endmodule

// File: rtl/mat_job_arbiter.sv
// Job-level round-robin arbiter sharing one matrix core between requesters.
// A grant covers a whole job: 20 words in, then 4 results back out.
module mat_job_arbiter
    import constants_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [ACC_WIDTH-1:0]          rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_rdy,
    output logic                          core_snk_vld,
    output logic [DATA_WIDTH-1:0]         core_snk_data,
    input  logic                          core_snk_rdy,
    input  logic                          core_src_vld,
    input  logic [ACC_WIDTH-1:0]          core_src_data,
    output logic                          core_src_rdy,
    output logic                          busy,
    output logic [GID_W-1:0]              grant_id,
    output logic [15:0]                   jobs_done
);
    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [GID_W-1:0]        r_grant_id;
    logic [GID_W-1:0]        r_rr_ptr;
    logic [WCNT_W-1:0]       r_wcnt;
    logic [RCNT_W-1:0]       r_rcnt;
    logic [15:0]             r_jobs_done;

    logic                    w_any;
    logic [GID_W-1:0]        w_pick;
    logic [GID_W-1:0]        w_ptr_next;
    logic [NUM_REQ-1:0]      w_gsel;
    logic [DATA_WIDTH-1:0]   w_gdata;
    logic                    w_gvld;
    logic                    w_grdy;
    logic                    w_snk_hs;
    logic                    w_src_hs;
    logic                    w_last_word;
    logic                    w_last_rsp;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GID_W   (GID_W)
    ) u_rr_pick (
        .req (req_vld),
        .ptr (r_rr_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    // Decode the grant into a one-hot select and mux the granted input word
    always_comb begin
        w_gsel  = '0;
        w_gdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant_id == GID_W'(j)) begin
                w_gsel[j] = 1'b1;
                w_gdata   = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_gvld      = |(req_vld & w_gsel);
    assign w_grdy      = |(rsp_rdy & w_gsel);
    assign w_snk_hs    = (r_state == ARB_FEED)  && w_gvld && core_snk_rdy;
    assign w_src_hs    = (r_state == ARB_DRAIN) && core_src_vld && w_grdy;
    assign w_last_word = (r_wcnt == WCNT_W'(JOB_WORDS - 1));
    assign w_last_rsp  = (r_rcnt == RCNT_W'(X_DEPTH - 1));
    // Next round starts just past the requester that was served
    assign w_ptr_next  = (r_grant_id == GID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ARB_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and pass-through routing; the granted pair is wired straight to the core
    always_comb begin
        w_next_state = r_state;
        req_rdy      = '0;
        rsp_vld      = '0;
        core_snk_vld = 1'b0;
        core_src_rdy = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) w_next_state = ARB_FEED;
            end
            ARB_FEED: begin
                core_snk_vld = w_gvld;
                req_rdy      = w_gsel & {NUM_REQ{core_snk_rdy}};
                if (w_snk_hs && w_last_word) w_next_state = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                rsp_vld      = w_gsel & {NUM_REQ{core_src_vld}};
                core_src_rdy = w_grdy;
                if (w_src_hs && w_last_rsp) w_next_state = ARB_IDLE;
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Grant capture, word/result counters, rotation pointer and job counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_jobs_done <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_pick;
                        r_wcnt     <= '0;
                    end
                end
                ARB_FEED: begin
                    if (w_snk_hs) begin
                        if (w_last_word) begin
                            r_wcnt <= '0;
                            r_rcnt <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                ARB_DRAIN: begin
                    if (w_src_hs) begin
                        if (w_last_rsp) begin
                            r_rcnt      <= '0;
                            r_rr_ptr    <= w_ptr_next;
                            r_jobs_done <= r_jobs_done + 16'd1;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_snk_data = w_gdata;
    assign rsp_data      = core_src_data;
    assign busy          = (r_state != ARB_IDLE);
    assign grant_id      = r_grant_id;
    assign jobs_done     = r_jobs_done;
endmodule

// File: tb/tb_mat_job_arbiter.sv
// Scoreboard bench for mat_job_arbiter with three requesters and a behavioural core.
module tb_mat_job_arbiter;
    import constants_pkg::*;

    localparam int NR = 3;
    localparam int DW = DATA_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        req_vld;
    logic [NR*DW-1:0]     req_data;
    logic [NR-1:0]        req_rdy;
    logic [NR-1:0]        rsp_vld;
    logic [ACC_WIDTH-1:0] rsp_data;
    logic [NR-1:0]        rsp_rdy;
    logic                 core_snk_vld;
    logic [DW-1:0]        core_snk_data;
    logic                 core_snk_rdy;
    logic                 core_src_vld;
    logic [ACC_WIDTH-1:0] core_src_data;
    logic                 core_src_rdy;
    logic                 busy;
    logic [1:0]           grant_id;
    logic [15:0]          jobs_done;

    logic [DW-1:0]        drv_data [NR];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NR; g++) begin : g_data
        assign req_data[g*DW +: DW] = drv_data[g];
    end

    mat_job_arbiter #(.NUM_REQ(NR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_vld       (req_vld),
        .req_data      (req_data),
        .req_rdy       (req_rdy),
        .rsp_vld       (rsp_vld),
        .rsp_data      (rsp_data),
        .rsp_rdy       (rsp_rdy),
        .core_snk_vld  (core_snk_vld),
        .core_snk_data (core_snk_data),
        .core_snk_rdy  (core_snk_rdy),
        .core_src_vld  (core_src_vld),
        .core_src_data (core_src_data),
        .core_src_rdy  (core_src_rdy),
        .busy          (busy),
        .grant_id      (grant_id),
        .jobs_done     (jobs_done)
    );

    logic [7:0]  wq    [NR][$];
    logic [31:0] exp_q [NR][$];
    int          gq[$];
    int          sent      [NR];
    int          gap_pos   [NR];
    int          gap_left  [NR];
    int          rsp_stall [NR];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one job: W is 1..16 row-major or identity, X given; results hand-computed by caller
    task automatic push_job(input int r, input bit ident,
                            input int x0, input int x1, input int x2, input int x3,
                            input int y0, input int y1, input int y2, input int y3);
        for (int k = 0; k < 16; k++)
            wq[r].push_back(ident ? ((k % 5 == 0) ? 8'd1 : 8'd0) : 8'(k + 1));
        wq[r].push_back(8'(x0)); wq[r].push_back(8'(x1));
        wq[r].push_back(8'(x2)); wq[r].push_back(8'(x3));
        exp_q[r].push_back(32'(y0)); exp_q[r].push_back(32'(y1));
        exp_q[r].push_back(32'(y2)); exp_q[r].push_back(32'(y3));
    endtask

    // Requester agents: present queued words, honour gaps and result back-pressure
    initial begin
        logic [NR-1:0] hs, rv;
        req_vld = '0;
        rsp_rdy = '1;
        for (int i = 0; i < NR; i++) begin
            drv_data[i] = '0; sent[i] = 0; gap_pos[i] = 0; gap_left[i] = 0; rsp_stall[i] = 0;
        end
        forever begin
            @(negedge clk);
            hs = req_vld & req_rdy;
            rv = rsp_vld;
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && wq[i].size() > 0) begin
                    void'(wq[i].pop_front());
                    sent[i]++;
                end
                if (gap_left[i] > 0 && sent[i] == gap_pos[i]) begin
                    req_vld[i] = 1'b0;
                    gap_left[i]--;
                end else if (wq[i].size() > 0) begin
                    req_vld[i]  = 1'b1;
                    drv_data[i] = wq[i][0];
                end else begin
                    req_vld[i] = 1'b0;
                end
                if (rv[i] && rsp_stall[i] > 0) begin
                    rsp_rdy[i] = 1'b0;
                    rsp_stall[i]--;
                end else begin
                    rsp_rdy[i] = 1'b1;
                end
            end
        end
    end

    // Behavioural matrix core: 20 words in, 3-cycle compute, y = W*x out
    initial begin
        logic [7:0]  buf_w [20];
        logic [31:0] y [4];
        int          phase, cnt, ocnt, dly;
        bit          shs, ohs;
        logic [7:0]  sw;
        phase = 0; cnt = 0; ocnt = 0; dly = 0;
        core_snk_rdy = 1'b0; core_src_vld = 1'b0; core_src_data = '0;
        for (int r = 0; r < 4; r++) y[r] = '0;
        forever begin
            @(negedge clk);
            shs = core_snk_vld && core_snk_rdy;
            ohs = core_src_vld && core_src_rdy;
            sw  = core_snk_data;
            @(posedge clk); #1;
            if (!rst_n) begin
                phase = 0; cnt = 0; ocnt = 0;
            end else begin
                case (phase)
                    0: if (shs) begin
                        buf_w[cnt] = sw;
                        cnt++;
                        if (cnt == 20) begin
                            for (int r = 0; r < 4; r++) begin
                                y[r] = '0;
                                for (int c = 0; c < 4; c++)
                                    y[r] = y[r] + 32'(buf_w[r*4+c]) * 32'(buf_w[16+c]);
                            end
                            cnt = 0; phase = 1; dly = 3;
                        end
                    end
                    1: begin
                        dly--;
                        if (dly == 0) phase = 2;
                    end
                    default: if (ohs) begin
                        ocnt++;
                        if (ocnt == 4) begin ocnt = 0; phase = 0; end
                    end
                endcase
            end
            core_snk_rdy  = (phase == 0);
            core_src_vld  = (phase == 2);
            core_src_data = y[ocnt];
        end
    end

    // Monitor: score results, grant order and per-cycle routing against the grant
    initial begin
        bit          prev_busy;
        logic [NR-1:0] allowed;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NR; i++) begin
                    if (rsp_vld[i] && rsp_rdy[i]) begin
                        if (exp_q[i].size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL rsp_unexpected: requester %0d got %0d with nothing expected", i, rsp_data);
                        end else begin
                            chk($sformatf("rsp_data[%0d]", i), rsp_data, exp_q[i].pop_front());
                        end
                    end
                end
                if (busy && !prev_busy) begin
                    if (gq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL grant_unexpected: got grant %0d with none expected", grant_id);
                    end else begin
                        chk("grant_order", 32'(grant_id), 32'(gq.pop_front()));
                    end
                end
                allowed = busy ? (NR'(1) << grant_id) : '0;
                chk("route_mask", 32'((req_rdy | rsp_vld) & ~allowed), 32'd0);
            end
            prev_busy = busy;
        end
    end

    task automatic wait_done(input string tag);
        int cyc = 0;
        while ((busy || wq[0].size() + wq[1].size() + wq[2].size() > 0 ||
                exp_q[0].size() + exp_q[1].size() + exp_q[2].size() > 0) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (2) @(posedge clk);
        #2;
        chk({tag, "_timeout"}, 32'(cyc >= 3000), 32'd0);
        chk({tag, "_grants_left"}, 32'(gq.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_snk_vld", 32'(core_snk_vld), 32'd0);
        chk("rst_src_rdy", 32'(core_src_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_jobs_done", 32'(jobs_done), 32'd0);
    endtask

    task automatic rst_assert();
        @(posedge clk); #2;
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            wq[i].delete(); exp_q[i].delete();
            gap_left[i] = 0; rsp_stall[i] = 0; sent[i] = 0;
        end
        gq.delete();
        @(negedge clk);
        check_reset_outputs();
    endtask

    task automatic rst_release();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_release();

        // Single requester 0, W = 1..16, X = 1s
        gq.push_back(0);
        push_job(0, 1'b0, 1, 1, 1, 1, 10, 26, 42, 58);
        wait_done("t1");
        chk("t1_jobs_done", 32'(jobs_done), 32'd1);
        chk("t1_grant_id", 32'(grant_id), 32'd0);

        // Requesters 0 and 1 both valid out of reset
        rst_assert();
        gq.push_back(0); gq.push_back(1);
        push_job(0, 1'b1, 3, 4, 5, 6, 3, 4, 5, 6);
        push_job(1, 1'b0, 1, 1, 1, 1, 10, 26, 42, 58);
        rst_release();
        wait_done("t2");
        chk("t2_jobs_done", 32'(jobs_done), 32'd2);
        chk("t2_grant_id", 32'(grant_id), 32'd1);

        // Requester 1 with a 3-cycle input gap and 5 cycles of result back-pressure
        sent[1] = 0; gap_pos[1] = 7; gap_left[1] = 3; rsp_stall[1] = 5;
        gq.push_back(1);
        push_job(1, 1'b0, 1, 2, 3, 4, 30, 70, 110, 150);
        wait_done("t3");
        chk("t3_jobs_done", 32'(jobs_done), 32'd3);

        // Identity W on requester 2, X = FF,01,80,00
        gq.push_back(2);
        push_job(2, 1'b1, 255, 1, 128, 0, 255, 1, 128, 0);
        wait_done("t4");
        chk("t4_jobs_done", 32'(jobs_done), 32'd4);
        chk("t4_grant_id", 32'(grant_id), 32'd2);

        // Reset after word 10, then a fresh job
        sent[0] = 0;
        gq.push_back(0);
        push_job(0, 1'b0, 1, 1, 1, 1, 10, 26, 42, 58);
        c = 0;
        while (sent[0] < 10 && c < 500) begin
            @(posedge clk); #2;
            c++;
        end
        chk("t5_word10_timeout", 32'(c >= 500), 32'd0);
        rst_assert();
        rst_release();
        gq.push_back(0);
        push_job(0, 1'b0, 2, 0, 0, 1, 6, 18, 30, 42);
        wait_done("t5");
        chk("t5_jobs_done", 32'(jobs_done), 32'd1);

        // Three requesters, three jobs each: grants rotate 0,1,2
        rst_assert();
        for (int j = 0; j < 3; j++) begin
            for (int r = 0; r < NR; r++) begin
                gq.push_back(r);
                push_job(r, 1'b1, r*16 + j*4 + 1, r*16 + j*4 + 2, r*16 + j*4 + 3, r*16 + j*4 + 4,
                                  r*16 + j*4 + 1, r*16 + j*4 + 2, r*16 + j*4 + 3, r*16 + j*4 + 4);
            end
        end
        rst_release();
        wait_done("t6");
        chk("t6_jobs_done", 32'(jobs_done), 32'd9);
        chk("t6_grant_id", 32'(grant_id), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
